// File: rtl/ex_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_divider_pkg                                                   |
// | Brief   : Op and state encodings shared by the EX-stage divider.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ex_divider_pkg;

    localparam logic [1:0] c_op_div  = 2'b00;
    localparam logic [1:0] c_op_divu = 2'b01;
    localparam logic [1:0] c_op_rem  = 2'b10;
    localparam logic [1:0] c_op_remu = 2'b11;

    localparam logic [1:0] c_s_idle = 2'b00;
    localparam logic [1:0] c_s_calc = 2'b01;
    localparam logic [1:0] c_s_fix  = 2'b10;
    localparam logic [1:0] c_s_done = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == c_op_div) || (op == c_op_rem);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == c_op_rem) || (op == c_op_remu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_divider_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : div_step                                                         |
// | Brief   : One combinational restoring-division iteration.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    // The shifted partial remainder carries one extra bit so the compare cannot wrap.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_shift = {i_acc, i_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign o_acc   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_q     = {i_q[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/ex_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_divider                                                       |
// | Brief   : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_stall
);

    import ex_divider_pkg::*;

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [1:0]         r_op;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;
    logic               r_busy;

    logic               w_signed;
    logic               w_sign_d;
    logic               w_sign_v;
    logic [WIDTH-1:0]   w_abs_dividend;
    logic [WIDTH-1:0]   w_abs_divisor;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_result;
    logic               w_accept;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_q;
    logic [WIDTH-1:0]   w_quotient;
    logic [WIDTH-1:0]   w_remainder;
    logic [WIDTH-1:0]   w_fix_result;

    assign w_signed       = op_is_signed(i_op);
    assign w_sign_d       = w_signed & i_dividend[WIDTH-1];
    assign w_sign_v       = w_signed & i_divisor[WIDTH-1];
    assign w_abs_dividend = w_sign_d ? -i_dividend : i_dividend;
    assign w_abs_divisor  = w_sign_v ? -i_divisor : i_divisor;

    assign w_div_zero = (i_divisor == '0);
    assign w_overflow = w_signed & (i_dividend == c_int_min) & (i_divisor == '1);
    assign w_special  = w_div_zero | w_overflow;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = op_is_rem(i_op) ? i_dividend : '1;
        end else begin
            w_special_result = op_is_rem(i_op) ? '0 : i_dividend;
        end
    end

    assign w_accept = (r_state == c_s_idle) & i_start & ~i_flush;
    assign o_stall  = w_accept | (r_state == c_s_calc) | (r_state == c_s_fix);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_q       (r_q),
        .i_divisor (r_divisor),
        .o_acc     (w_step_acc),
        .o_q       (w_step_q)
    );

    assign w_quotient   = r_sign_q ? -r_q : r_q;
    assign w_remainder  = r_sign_r ? -r_acc : r_acc;
    assign w_fix_result = op_is_rem(r_op) ? w_remainder : w_quotient;

    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = c_s_idle;
        end else begin
            case (r_state)
                c_s_idle: if (i_start) w_next_state = w_special ? c_s_done : c_s_calc;
                c_s_calc: if (r_count == c_cnt_one) w_next_state = c_s_fix;
                c_s_fix:  w_next_state = c_s_done;
                default:  w_next_state = c_s_idle;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= c_s_idle;
            r_count   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_op      <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != c_s_idle);
            r_done  <= 1'b0;
            if (!i_flush) begin
                case (r_state)
                    c_s_idle: begin
                        if (i_start) begin
                            r_q       <= w_abs_dividend;
                            r_divisor <= w_abs_divisor;
                            r_op      <= i_op;
                            r_sign_q  <= w_sign_d ^ w_sign_v;
                            r_sign_r  <= w_sign_d;
                            r_count   <= c_cnt_init;
                            r_acc     <= '0;
                            if (w_special) begin
                                r_result <= w_special_result;
                                r_done   <= 1'b1;
                            end
                        end
                    end
                    c_s_calc: begin
                        r_acc   <= w_step_acc;
                        r_q     <= w_step_q;
                        r_count <= r_count - c_cnt_one;
                    end
                    c_s_fix: begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_result = r_result;
    assign o_done   = r_done;
    assign o_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ex_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ex_divider                                                    |
// | Brief   : Directed self-checking bench for ex_divider (WIDTH=32).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ex_divider;

    logic        i_clock;
    logic        i_reset;
    logic        i_start;
    logic        i_flush;
    logic [1:0]  i_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_result;
    logic        o_done;
    logic        o_busy;
    logic        o_stall;

    int n_checks = 0;
    int n_pass   = 0;

    ex_divider #(.WIDTH(32)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_flush    (i_flush),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_result   (o_result),
        .o_done     (o_done),
        .o_busy     (o_busy),
        .o_stall    (o_stall)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 2 time units after the edge, outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        i_start = 1'b1; i_op = op; i_dividend = a; i_divisor = b;
        #1;
        chk({tag, "_stall_start"}, {31'b0, o_stall}, 32'd1);
        tick();
        i_start = 1'b0;
        #1;
        for (int k = 1; k < lat; k++) begin
            chk({tag, "_stall_iter"}, {31'b0, o_stall}, 32'd1);
            chk({tag, "_done_early"}, {31'b0, o_done}, 32'd0);
            tick();
            #1;
        end
        chk({tag, "_done"}, {31'b0, o_done}, 32'd1);
        chk({tag, "_stall_done"}, {31'b0, o_stall}, 32'd0);
        chk({tag, "_busy_done"}, {31'b0, o_busy}, 32'd1);
        chk({tag, "_result"}, o_result, exp);
        tick();
        #1;
        chk({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
        chk({tag, "_busy_idle"}, {31'b0, o_busy}, 32'd0);
        chk({tag, "_result_hold"}, o_result, exp);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_op = 2'b00; i_dividend = '0; i_divisor = '0;
        tick();
        tick();
        #1;
        chk("rst_result", o_result, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        i_reset = 1'b0;
        tick();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 34, 32'd14);
        run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE);
        run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2);
        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1, 32'd5);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 34, 32'd1);

        // Flush together with start in IDLE: not accepted.
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_dividend = 32'd50; i_divisor = 32'd5;
        #1;
        chk("flush_start_stall", {31'b0, o_stall}, 32'd0);
        tick();
        i_start = 1'b0; i_flush = 1'b0;
        #1;
        chk("flush_start_busy", {31'b0, o_busy}, 32'd0);
        chk("flush_start_done", {31'b0, o_done}, 32'd0);

        // Flush mid-CALC at t+10.
        i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd3;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            #1;
            chk("flush_busy_calc", {31'b0, o_busy}, 32'd1);
            tick();
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk("flush_busy", {31'b0, o_busy}, 32'd0);
        chk("flush_done", {31'b0, o_done}, 32'd0);
        chk("flush_stall", {31'b0, o_stall}, 32'd0);
        chk("flush_result_kept", o_result, 32'd1);
        run_op("divu_after_flush", 2'b01, 32'd1000, 32'd3, 34, 32'd333);

        // Reset mid-CALC at t+5.
        i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd3;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        chk("reset_mid_busy", {31'b0, o_busy}, 32'd0);
        chk("reset_mid_result", o_result, 32'd0);
        chk("reset_mid_done", {31'b0, o_done}, 32'd0);

        run_op("divu_ffff_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF);
        run_op("remu_9_4", 2'b11, 32'd9, 32'd4, 34, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
